// File: rtl/video_pkg.sv
// video_pkg: types and constants shared by the capture stage (video_in)
// and the display stage that reads the captured frame back.
//   video_in_state_t - capture FSM states
//   SEL_ALL          - Wishbone byte-select for full 32-bit writes
//   IMAGE_WIDTH/HEIGHT - nominal frame geometry shared with the display stage
package video_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        FLUSH,
        DRAIN,
        DONE
    } video_in_state_t;

    localparam logic [3:0] SEL_ALL      = 4'hF;
    localparam int         IMAGE_WIDTH  = 640;
    localparam int         IMAGE_HEIGHT = 480;

endpackage

// File: rtl/video_in_word_fifo.sv
// word_fifo: single-clock synchronous FIFO of 32-bit words.
//   p_clk, p_reset        - clock, synchronous active-high reset (empties FIFO)
//   push, push_data       - write request and data; ignored when full unless
//                           a pop happens in the same cycle
//   pop                   - remove the head word (ignored when empty)
//   head                  - current head word (valid when !empty)
//   full, empty           - occupancy flags
module word_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        p_clk,
    input  logic        p_reset,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO is accepted.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge p_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/video_in.sv
// video_in: camera capture stage. Packs 8-bit pixels (four per word, first
// pixel in bits [7:0]) and writes the words to RAM with Wishbone single
// writes starting at a base address latched at frame start. Pulses irq for
// one cycle once the whole frame is committed.
//   p_clk, p_reset            - clock, synchronous active-high reset
//   frame_valid, line_valid   - pixel qualifiers; pixel_in taken when both high
//   cfg_enable, cfg_base      - arm request and base address (sampled at frame start)
//   irq                       - one-cycle frame-done pulse
//   overflow, bus_err         - sticky status, cleared at the next captured frame start
//   frame_words               - words acked (ACK or ERR) for the last/current frame
//   p_wb_*                    - Wishbone master write port
module video_in
    import video_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] DEFAULT_BASE = 32'h4100_0000
) (
    input  logic        p_clk,
    input  logic        p_reset,
    input  logic        frame_valid,
    input  logic        line_valid,
    input  logic [7:0]  pixel_in,
    input  logic        cfg_enable,
    input  logic [31:0] cfg_base,
    output logic        irq,
    output logic        overflow,
    output logic        bus_err,
    output logic [31:0] frame_words,
    output logic [31:0] p_wb_DAT_O,
    output logic [31:0] p_wb_ADR_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_WE_O,
    output logic        p_wb_LOCK_O,
    input  logic [31:0] p_wb_DAT_I,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I,
    input  logic        p_wb_RTY_I
);

    video_in_state_t state, state_nxt;

    logic        fv_q;
    logic        frame_start, frame_end, capture_start, pix_take;
    logic [1:0]  pack_cnt;
    logic [31:0] pack_word;
    logic        push, pop;
    logic [31:0] push_data;
    logic        fifo_full, fifo_empty;
    logic [31:0] fifo_head;
    logic [31:0] wr_addr;
    logic        wb_cyc;
    logic        unused_dat_i;

    assign unused_dat_i  = ^p_wb_DAT_I;

    assign frame_start   = frame_valid && !fv_q;
    assign frame_end     = !frame_valid && fv_q;
    assign capture_start = (state == ARMED) && frame_start && cfg_enable;
    assign pix_take      = (state == CAPTURE) && frame_valid && line_valid;
    assign pop           = wb_cyc && (p_wb_ACK_I || p_wb_ERR_I);

    // Full word goes straight from the pixel input so it is pushed on the
    // fourth byte's cycle; a partial word at frame end relies on pack_word
    // having its unused upper bytes already zero.
    always_comb begin
        push      = 1'b0;
        push_data = pack_word;
        if (pix_take && pack_cnt == 2'd3) begin
            push      = 1'b1;
            push_data = {pixel_in, pack_word[23:0]};
        end else if (state == FLUSH && pack_cnt != 2'd0) begin
            push      = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cfg_enable)               state_nxt = ARMED;
            ARMED:   if (capture_start)            state_nxt = CAPTURE;
            CAPTURE: if (frame_end)                state_nxt = FLUSH;
            FLUSH:                                 state_nxt = DRAIN;
            DRAIN:   if (fifo_empty && !wb_cyc)    state_nxt = DONE;
            DONE:    state_nxt = cfg_enable ? ARMED : IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    // Capture side: FSM state, edge detect, byte packing, overflow flag.
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state     <= IDLE;
            fv_q      <= 1'b0;
            pack_cnt  <= 2'd0;
            pack_word <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            fv_q  <= frame_valid;
            if (capture_start) begin
                pack_cnt  <= 2'd0;
                pack_word <= '0;
                overflow  <= 1'b0;
            end else if (pix_take) begin
                if (pack_cnt == 2'd3) pack_word <= '0;
                else                  pack_word[{pack_cnt, 3'b000} +: 8] <= pixel_in;
                pack_cnt <= pack_cnt + 2'd1;
            end else if (state == FLUSH) begin
                pack_cnt  <= 2'd0;
                pack_word <= '0;
            end
            // Dropped words do not advance the address: the writer only
            // advances on words it actually sends.
            if (push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    // Wishbone writer: runs whenever there is a word and no open cycle.
    // Capture can only start from ARMED, where the FIFO is empty and the
    // writer idle, so the base latch never races an active write.
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            wb_cyc      <= 1'b0;
            p_wb_ADR_O  <= '0;
            p_wb_DAT_O  <= '0;
            wr_addr     <= DEFAULT_BASE;
            frame_words <= '0;
            bus_err     <= 1'b0;
        end else begin
            if (capture_start) begin
                wr_addr     <= cfg_base;
                frame_words <= '0;
                bus_err     <= 1'b0;
            end
            if (wb_cyc) begin
                if (p_wb_ACK_I || p_wb_ERR_I) begin
                    wb_cyc      <= 1'b0;
                    wr_addr     <= wr_addr + 32'd4;
                    frame_words <= frame_words + 32'd1;
                    if (p_wb_ERR_I) bus_err <= 1'b1;
                end else if (p_wb_RTY_I) begin
                    // Head stays in the FIFO; reissued after one idle cycle.
                    wb_cyc <= 1'b0;
                end
            end else if (!fifo_empty) begin
                wb_cyc     <= 1'b1;
                p_wb_ADR_O <= wr_addr;
                p_wb_DAT_O <= fifo_head;
            end
        end
    end

    assign p_wb_STB_O  = wb_cyc;
    assign p_wb_CYC_O  = wb_cyc;
    assign p_wb_WE_O   = wb_cyc;
    assign p_wb_SEL_O  = SEL_ALL;
    assign p_wb_LOCK_O = 1'b0;
    assign irq         = (state == DONE);

    word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .p_clk     (p_clk),
        .p_reset   (p_reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_video_in.sv
// tb_video_in: directed + randomized bench for video_in. A reference model
// turns the pixel list of each frame into the expected word/address list;
// a Wishbone slave model with configurable wait/RTY/ERR records every
// accepted write for comparison.
module tb_video_in;

    localparam int DEPTH = 4;

    logic        p_clk = 1'b0;
    logic        p_reset;
    logic        fv, lv, cfg_en;
    logic [7:0]  pix;
    logic [31:0] cfg_base;
    logic        irq, overflow, bus_err;
    logic [31:0] frame_words, dat_o, adr_o, dat_i;
    logic [3:0]  sel;
    logic        stb, cyc, we, lock, ack, err, rty;

    int tests = 0, fails = 0, irq_cnt = 0, rty_cnt = 0, wt = -1;
    int min_wait = 0, max_wait = 0;
    bit stall = 0, rty_next = 0, err_next = 0;
    logic [31:0] rty_a, rty_d;
    logic [7:0]  px[$];
    logic [31:0] exp_w[$], obs_a[$], obs_d[$];

    video_in #(.FIFO_DEPTH(DEPTH), .DEFAULT_BASE(32'h4100_0000)) dut (
        .p_clk(p_clk), .p_reset(p_reset),
        .frame_valid(fv), .line_valid(lv), .pixel_in(pix),
        .cfg_enable(cfg_en), .cfg_base(cfg_base),
        .irq(irq), .overflow(overflow), .bus_err(bus_err), .frame_words(frame_words),
        .p_wb_DAT_O(dat_o), .p_wb_ADR_O(adr_o), .p_wb_SEL_O(sel),
        .p_wb_STB_O(stb), .p_wb_CYC_O(cyc), .p_wb_WE_O(we), .p_wb_LOCK_O(lock),
        .p_wb_DAT_I(dat_i), .p_wb_ACK_I(ack), .p_wb_ERR_I(err), .p_wb_RTY_I(rty)
    );

    initial forever #5 p_clk = ~p_clk;

    // Wishbone slave: responds after wt wait states; response held across
    // exactly one rising edge.
    initial begin
        ack = 0; err = 0; rty = 0; dat_i = 32'h0;
        forever begin
            @(negedge p_clk);
            ack = 0; err = 0; rty = 0;
            if (p_reset) wt = -1;
            else if (stb && !stall) begin
                if (wt < 0) wt = int'($urandom_range(max_wait, min_wait));
                if (wt == 0) begin
                    wt = -1;
                    if (rty_next) begin
                        rty = 1; rty_next = 0; rty_cnt++; rty_a = adr_o; rty_d = dat_o;
                    end else begin
                        if (err_next) begin err = 1; err_next = 0; end
                        else ack = 1;
                        obs_a.push_back(adr_o);
                        obs_d.push_back(dat_o);
                    end
                end else wt--;
            end
        end
    end

    initial forever begin
        @(negedge p_clk);
        if (irq === 1'b1) irq_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge p_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Reference model: bytes packed little-endian, last word zero-padded.
    task automatic build_exp();
        logic [31:0] w;
        exp_w.delete();
        for (int i = 0; i < (px.size() + 3) / 4; i++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++)
                if (4*i + b < px.size()) w = w | (32'(px[4*i+b]) << (8*b));
            exp_w.push_back(w);
        end
    endtask

    task automatic fill_px(input int n, input int first);
        px.delete();
        for (int i = 0; i < n; i++)
            px.push_back((first < 0) ? 8'($urandom) : 8'(first + i));
    endtask

    task automatic send_frame(input int line_w, input int gap, input int en_at,
                              input logic [31:0] base_after);
        fv = 1; tick(1);
        cfg_base = base_after; tick(1);
        for (int i = 0; i < px.size(); i++) begin
            if (i == en_at) cfg_en = 1;
            lv = 1; pix = px[i]; tick(1);
            if ((i + 1) % line_w == 0) begin
                lv = 0; tick(2);
            end else if (gap > 0 && $urandom_range(3, 0) == 0) begin
                lv = 0; tick(int'($urandom_range(gap, 1)));
            end
        end
        lv = 0; pix = 8'h0; tick(2);
        fv = 0; tick(1);
    endtask

    task automatic wait_irq(input int c0);
        int n = 0;
        while (irq_cnt == c0 && n < 3000) begin tick(1); n++; end
        chk("irq_seen", 32'(irq_cnt != c0), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [31:0] base, input int line_w,
                             input int gap, input bit e_err, input logic [31:0] base_after);
        int c0;
        int m;
        cfg_base = base;
        obs_a.delete(); obs_d.delete();
        build_exp();
        c0 = irq_cnt;
        send_frame(line_w, gap, -1, base_after);
        wait_irq(c0);
        tick(6);
        chk({tag, "_irq_count"}, 32'(irq_cnt - c0), 32'd1);
        chk({tag, "_n_writes"}, 32'(obs_a.size()), 32'(exp_w.size()));
        m = (obs_a.size() < exp_w.size()) ? obs_a.size() : exp_w.size();
        for (int i = 0; i < m; i++) begin
            chk({tag, "_adr"}, obs_a[i], base + 32'(4*i));
            chk({tag, "_dat"}, obs_d[i], exp_w[i]);
        end
        chk({tag, "_frame_words"}, frame_words, 32'(exp_w.size()));
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'(e_err));
    endtask

    initial begin
        int c0, n;
        logic [31:0] b;
        p_reset = 1; fv = 0; lv = 0; pix = 0; cfg_en = 0; cfg_base = 32'h0;
        tick(3);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_sel", 32'(sel), 32'hF);
        chk("rst_adr", adr_o, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_berr", 32'(bus_err), 32'd0);
        chk("rst_fwords", frame_words, 32'h0);
        p_reset = 0; cfg_en = 1; tick(2);

        // 4x2 frame, one wait state
        min_wait = 1; max_wait = 1;
        fill_px(8, 0);
        run_frame("t1", 32'h4100_0000, 4, 0, 0, 32'h4100_0000);

        // partial last word
        fill_px(6, 8'hA1);
        run_frame("t2", 32'h4100_0000, 6, 0, 0, 32'h4100_0000);

        // retry on first attempt
        min_wait = 0; max_wait = 2;
        rty_next = 1; n = rty_cnt;
        fill_px(8, 8'h10);
        run_frame("t4", 32'h4200_0100, 4, 1, 0, 32'h4200_0100);
        chk("t4_rty_cnt", 32'(rty_cnt - n), 32'd1);
        chk("t4_rty_adr", rty_a, 32'h4200_0100);
        chk("t4_rty_dat", rty_d, exp_w[0]);

        // error response: still counted, bus_err set
        err_next = 1;
        fill_px(12, -1);
        run_frame("terr", 32'h4300_0000, 4, 1, 1, 32'h4300_0000);

        // address wraps modulo 2^32; bus_err cleared at capture
        fill_px(16, -1);
        run_frame("twrap", 32'hFFFF_FFF8, 8, 1, 0, 32'hFFFF_FFF8);

        // randomized frames
        min_wait = 0; max_wait = 3;
        for (int k = 0; k < 6; k++) begin
            fill_px(int'($urandom_range(16, 1)), -1);
            rty_next = bit'($urandom_range(1, 0));
            b = $urandom & 32'hFFFF_FFFC;
            run_frame("trand", b, int'($urandom_range(8, 2)), 2, 0, $urandom & 32'hFFFF_FFFC);
        end

        // overflow: slave stalls well past the end of a 64-pixel frame
        stall = 1;
        fill_px(64, -1);
        build_exp();
        cfg_base = 32'h4400_0000;
        obs_a.delete(); obs_d.delete();
        c0 = irq_cnt;
        send_frame(64, 0, -1, 32'h4400_0000);
        tick(30);
        stall = 0;
        wait_irq(c0);
        tick(6);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_irq_count", 32'(irq_cnt - c0), 32'd1);
        chk("t3_n_writes", 32'(obs_a.size()), 32'(DEPTH));
        chk("t3_frame_words", frame_words, 32'(DEPTH));
        for (int i = 0; i < obs_a.size() && i < DEPTH; i++) begin
            chk("t3_adr", obs_a[i], 32'h4400_0000 + 32'(4*i));
            chk("t3_dat", obs_d[i], exp_w[i]);
        end
        // next captured frame clears overflow (checked inside)
        fill_px(8, -1);
        run_frame("t3b", 32'h4400_1000, 4, 0, 0, 32'h4400_1000);

        // enable raised mid-frame: frame skipped, next frame captured at
        // the base present at its rising edge
        cfg_en = 0; tick(3);
        fill_px(8, -1);
        obs_a.delete(); obs_d.delete();
        c0 = irq_cnt;
        send_frame(4, 0, 3, 32'h4500_0000);
        tick(40);
        chk("t5_skip_writes", 32'(obs_a.size()), 32'd0);
        chk("t5_skip_irq", 32'(irq_cnt - c0), 32'd0);
        fill_px(8, 8'h40);
        run_frame("t5", 32'h4600_0000, 4, 0, 0, 32'h4700_0000);

        // reset during an open write cycle
        stall = 1;
        fill_px(8, -1);
        obs_a.delete(); obs_d.delete();
        c0 = irq_cnt;
        cfg_base = 32'h4800_0000;
        send_frame(8, 0, -1, 32'h4800_0000);
        n = 0;
        while (stb !== 1'b1 && n < 50) begin tick(1); n++; end
        chk("t6_stb_open", 32'(stb), 32'd1);
        p_reset = 1; tick(1);
        chk("t6_stb", 32'(stb), 32'd0);
        chk("t6_cyc", 32'(cyc), 32'd0);
        chk("t6_irq", 32'(irq), 32'd0);
        chk("t6_adr", adr_o, 32'h0);
        chk("t6_fwords", frame_words, 32'h0);
        p_reset = 0; stall = 0;
        tick(30);
        chk("t6_no_irq", 32'(irq_cnt - c0), 32'd0);
        chk("t6_no_writes", 32'(obs_a.size()), 32'd0);
        chk("t6_stb_idle", 32'(stb), 32'd0);
        fill_px(10, -1);
        run_frame("t6b", 32'h4900_0000, 5, 1, 0, 32'h4900_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
